// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding and
// a ceiling-log2 helper used to size the slice index.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca.sv
// Combinational CHUNK-bit ripple-carry slice built from full adders; also
// exposes the carry into the top bit so the caller can derive signed overflow.
module rca_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB slice first,
// through a shared ripple slice and a registered carry, with start/busy/done.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? int'(clog2(NCHUNK)) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] a_l, b_l;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] xs, ys, sum;
  logic             co, c_msb;

  assign xs = a_l[idx*CHUNK +: CHUNK];
  assign ys = b_l[idx*CHUNK +: CHUNK];

  rca_chunk #(.CHUNK(CHUNK)) u_slice (
    .x     (xs),
    .y     (ys),
    .ci    (carry),
    .sum   (sum),
    .co    (co),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Subtraction is a + ~b + 1 with cin acting as borrow, folded in at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_l   <= '0;
      b_l   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_l   <= a;
            b_l   <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            idx   <= '0;
            s     <= '0;
          end
        end
        RUN: begin
          s[idx*CHUNK +: CHUNK] <= sum;
          carry                 <= co;
          if (idx == LAST) begin
            ovf  <= c_msb ^ co;
            cout <= co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: directed cases on the (8,2) build,
// random add/sub against a behavioural reference on (8,1), (8,8) and (16,4).
module tb_seq_chunk_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic score(input string tag, input logic [15:0] got_s, input logic got_c,
                       input logic got_o, input int br, input exp_t e, input int n);
    check({tag, "_s"}, got_s, e.s);
    check({tag, "_cout"}, got_c, e.c);
    check({tag, "_ovf"}, got_o, e.o);
    check({tag, "_latency"}, cyc - e.acc, n);
    check({tag, "_busy_cycles"}, br, n);
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input int acc);
    exp_t m;
    logic [15:0] mask, aa, bb;
    logic [16:0] full;
    mask  = 16'((17'd1 << w) - 17'd1);
    aa    = a & mask;
    bb    = (sub ? ~b : b) & mask;
    full  = {1'b0, aa} + {1'b0, bb} + 17'(cin ^ sub);
    m.s   = full[15:0] & mask;
    m.c   = full[w];
    m.o   = (aa[w-1] == bb[w-1]) && (m.s[w-1] != aa[w-1]);
    m.acc = acc;
    return m;
  endfunction

  // main (8,2) instance
  logic       start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] s;
  exp_t       q0[$];

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  // sweep instances share one set of inputs
  logic        sw_start = 1'b0, sw_sub = 1'b0, sw_cin = 1'b0;
  logic [15:0] sw_a = '0, sw_b = '0;
  logic        busy1, done1, cout1, ovf1;
  logic        busy2, done2, cout2, ovf2;
  logic        busy3, done3, cout3, ovf3;
  logic [7:0]  s1, s2;
  logic [15:0] s3;
  exp_t        q1[$], q2[$], q3[$];

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u81 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
  );
  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u88 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2)
  );
  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u164 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .busy(busy3), .done(done3), .s(s3), .cout(cout3), .ovf(ovf3)
  );

  // output monitors
  int   br0 = 0, br1 = 0, br2 = 0, br3 = 0;
  logic dp0 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (dp0 && done) check("done_width", done, 1'b0);
    dp0 = done;
    if (busy) br0++; else if (!done) br0 = 0;
    if (done) begin
      if (q0.size() == 0) check("spurious_done", done, 1'b0);
      else begin
        e = q0.pop_front();
        score("w8c2", {8'h00, s}, cout, ovf, br0, e, 4);
      end
      br0 = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy1) br1++; else if (!done1) br1 = 0;
    if (done1) begin
      if (q1.size() == 0) check("w8c1_spurious_done", done1, 1'b0);
      else begin e = q1.pop_front(); score("w8c1", {8'h00, s1}, cout1, ovf1, br1, e, 8); end
      br1 = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy2) br2++; else if (!done2) br2 = 0;
    if (done2) begin
      if (q2.size() == 0) check("w8c8_spurious_done", done2, 1'b0);
      else begin e = q2.pop_front(); score("w8c8", {8'h00, s2}, cout2, ovf2, br2, e, 1); end
      br2 = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy3) br3++; else if (!done3) br3 = 0;
    if (done3) begin
      if (q3.size() == 0) check("w16c4_spurious_done", done3, 1'b0);
      else begin e = q3.pop_front(); score("w16c4", s3, cout3, ovf3, br3, e, 4); end
      br3 = 0;
    end
  end

  task automatic wait_main();
    for (int k = 0; k < 40 && q0.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    if (q0.size() != 0) begin
      check("main_timeout", q0.size(), 0);
      q0.delete();
    end
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                    input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    q0.push_back('{{8'h00, es}, ec, eo, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    wait_main();
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] s;
    logic       c, o;
  } vec_t;

  vec_t vecs[8] = '{
    '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0},
    '{8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0},
    '{8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0},
    '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
    '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0}
  };

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", s, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_s16", s3, 16'h0000);
    rst = 1'b0;

    foreach (vecs[i])
      op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].o);

    // start held high and operands churned through RUN and DONE
    @(negedge clk);
    a = 8'h21; b = 8'h12; cin = 1'b0; sub = 1'b0; start = 1'b1;
    q0.push_back('{16'h0033, 1'b0, 1'b0, cyc + 1});
    repeat (5) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_s", s, 8'h33);
    check("hold_busy", busy, 1'b0);
    check("hold_queue", q0.size(), 0);

    // reset during the second RUN cycle aborts without done
    @(negedge clk);
    a = 8'h40; b = 8'h40; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_s", s, 8'h00);
    repeat (8) @(negedge clk);
    op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      case (i)
        0:       {sw_a, sw_b, sw_cin, sw_sub} = {16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        1:       {sw_a, sw_b, sw_cin, sw_sub} = {16'h8000, 16'h0001, 1'b0, 1'b1};
        2:       {sw_a, sw_b, sw_cin, sw_sub} = {16'h7F7F, 16'h0101, 1'b0, 1'b0};
        3:       {sw_a, sw_b, sw_cin, sw_sub} = {16'h0000, 16'h0000, 1'b1, 1'b1};
        default: {sw_a, sw_b, sw_cin, sw_sub} = {16'($urandom), 16'($urandom), 2'($urandom)};
      endcase
      sw_start = 1'b1;
      q1.push_back(model(8, sw_a, sw_b, sw_cin, sw_sub, cyc + 1));
      q2.push_back(model(8, sw_a, sw_b, sw_cin, sw_sub, cyc + 1));
      q3.push_back(model(16, sw_a, sw_b, sw_cin, sw_sub, cyc + 1));
      @(negedge clk);
      sw_start = 1'b0;
      sw_a = 16'($urandom); sw_b = 16'($urandom); sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      for (int k = 0; k < 40 && (q1.size() + q2.size() + q3.size()) != 0; k++) begin
        @(negedge clk); #1;
      end
      if ((q1.size() + q2.size() + q3.size()) != 0) begin
        check("sweep_timeout", q1.size() + q2.size() + q3.size(), 0);
        q1.delete(); q2.delete(); q3.delete();
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end

endmodule
